// File: rtl/data_mem_bridge.sv
// -----------------------------------------------------------------------------
// data_mem_bridge
//
// Purpose:
//    Bridges a core-side data request interface (req/gnt, rvalid response)
//    to a synchronous single-port SRAM. Each granted request is captured,
//    optionally stalled for WAIT_CYCLES cycles, issued to the SRAM for exactly
//    one cycle and answered with a single rvalid pulse. Reads return the SRAM
//    data; writes return zero.
//
// Parameters:
//    WAIT_CYCLES   extra stall cycles (0..15) before each SRAM access
//
// Configuration macro:
//    DATA_MEM_MISALIGN_CHECK_EN  when defined, misaligned word/halfword
//                                requests are answered with data_err_o=1 and
//                                never reach the SRAM. When undefined, address
//                                bits [1:0] are simply dropped.
//
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    data_req_i          core request, held until granted
//    data_addr_i         byte address
//    data_wr_i           1 = write, 0 = read
//    data_be_i           byte enables
//    data_wdata_i        write data
//    data_gnt_o          request accepted this cycle
//    data_rvalid_o       one-cycle response pulse
//    data_rdata_o        read data (valid with rvalid, else 0)
//    data_err_o          error flag (valid with rvalid, else 0)
//    mem_cs_o, mem_we_o  SRAM chip select / write enable
//    mem_addr_o          SRAM word address
//    mem_be_o            SRAM byte enables
//    mem_wdata_o         SRAM write data
//    mem_rdata_i         SRAM read data (valid the cycle after mem_cs_o)
// -----------------------------------------------------------------------------

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_TRANSFER_WIDTH
`define MEM_TRANSFER_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module data_mem_bridge #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            data_req_i,
   input  logic [`MEM_ADDR_WIDTH-1:0]      data_addr_i,
   input  logic                            data_wr_i,
   input  logic [`MEM_TRANSFER_WIDTH-1:0]  data_be_i,
   input  logic [`DATA_WIDTH-1:0]          data_wdata_i,
   output logic                            data_gnt_o,
   output logic                            data_rvalid_o,
   output logic [`DATA_WIDTH-1:0]          data_rdata_o,
   output logic                            data_err_o,
   output logic                            mem_cs_o,
   output logic                            mem_we_o,
   output logic [`MEM_ADDR_WIDTH-3:0]      mem_addr_o,
   output logic [`MEM_TRANSFER_WIDTH-1:0]  mem_be_o,
   output logic [`DATA_WIDTH-1:0]          mem_wdata_o,
   input  logic [`DATA_WIDTH-1:0]          mem_rdata_i
);

   localparam int AW = `MEM_ADDR_WIDTH;
   localparam int BW = `MEM_TRANSFER_WIDTH;
   localparam int DW = `DATA_WIDTH;

   // Counter reload value: WAIT is entered with WAIT_CYCLES-1 so that the
   // state is occupied for exactly WAIT_CYCLES cycles.
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [3:0]      count_reg, count_next;
   logic [AW-3:0]   addr_reg, addr_next;
   logic            wr_reg, wr_next;
   logic [BW-1:0]   be_reg, be_next;
   logic [DW-1:0]   wdata_reg, wdata_next;
   logic            err_reg, err_next;
   logic            misalign;
   logic            access_active;

   // ---------------------------------------------------------------------
   // Misalignment detection (optional)
   // ---------------------------------------------------------------------
`ifdef DATA_MEM_MISALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      if (data_be_i == BW'(4'b1111) && data_addr_i[1:0] != 2'b00) begin
         misalign = 1'b1;
      end
      if ((data_be_i == BW'(4'b0011) || data_be_i == BW'(4'b1100)) && data_addr_i[0]) begin
         misalign = 1'b1;
      end
   end
`else
   // Sub-word address bits carry no meaning for the SRAM in this build.
   logic unused_addr_bits;
   assign unused_addr_bits = ^data_addr_i[1:0];
   assign misalign         = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // State and request capture registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         count_reg <= '0;
         addr_reg  <= '0;
         wr_reg    <= 1'b0;
         be_reg    <= '0;
         wdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         addr_reg  <= addr_next;
         wr_reg    <= wr_next;
         be_reg    <= be_next;
         wdata_reg <= wdata_next;
         err_reg   <= err_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      addr_next     = addr_reg;
      wr_next       = wr_reg;
      be_next       = be_reg;
      wdata_next    = wdata_reg;
      err_next      = err_reg;
      data_gnt_o    = 1'b0;
      data_rvalid_o = 1'b0;
      data_rdata_o  = '0;
      data_err_o    = 1'b0;
      mem_cs_o      = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      mem_be_o      = '0;

      case (state_reg)
         IDLE: begin
            // Grant is combinational on the request, but suppressed while
            // reset is held so that every output is quiet during reset.
            data_gnt_o = data_req_i & rst_n;
            if (data_req_i) begin
               addr_next  = data_addr_i[AW-1:2];
               wr_next    = data_wr_i;
               be_next    = data_be_i;
               wdata_next = data_wdata_i;
               err_next   = misalign;
               if (misalign) begin
                  // Error responses bypass the SRAM entirely.
                  state_next = RESP;
               end else if (WAIT_CYCLES > 0) begin
                  count_next = WAIT_LOAD;
                  state_next = WAIT;
               end else begin
                  state_next = ACCESS;
               end
            end
         end

         WAIT: begin
            if (count_reg == 4'd0) begin
               state_next = ACCESS;
            end else begin
               count_next = count_reg - 4'd1;
            end
         end

         ACCESS: begin
            mem_cs_o   = 1'b1;
            mem_we_o   = wr_reg;
            mem_addr_o = addr_reg;
            mem_be_o   = be_reg;
            state_next = RESP;
         end

         RESP: begin
            data_rvalid_o = 1'b1;
            data_err_o    = err_reg;
            // SRAM read data is valid in this cycle (one after chip select);
            // writes and error responses return zero.
            if (!wr_reg && !err_reg) begin
               data_rdata_o = mem_rdata_i;
            end
            err_next   = 1'b0;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Write data lanes: driven only during the access cycle, zero otherwise
   // ---------------------------------------------------------------------
   assign access_active = (state_reg == ACCESS);

   for (genvar gi = 0; gi < BW; gi++) begin : g_wdata_lane
      assign mem_wdata_o[gi*8 +: 8] = access_active ? wdata_reg[gi*8 +: 8] : 8'h00;
   end

endmodule
